// File: rtl/ps2_host_tx_if.sv
// Command-byte request/response bundle between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       rx_inhibit;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_done,
        input  tx_err,
        input  rx_inhibit
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_done,
        output tx_err,
        output rx_inhibit
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts one byte with odd parity
// on device clock falls and checks the device ACK. Drives open-drain pull-down enables only.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave tx_if,
    input  logic         i_ps2_clk,
    input  logic         i_ps2_data,
    output logic         o_ps2_clk_oe,
    output logic         o_ps2_data_oe
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_STOP,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_ERR
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic [INH_W-1:0]       r_inh_cnt;
    logic [TMO_W-1:0]       r_tmo_cnt;
    logic [8:0]             r_shift;
    logic [3:0]             r_bit_cnt;

    logic w_clk_s;
    logic w_data_s;
    logic w_fe;
    logic w_timed;
    logic w_tmo_hit;

    assign w_clk_s   = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s  = r_data_sync[SYNC_STAGES-1];
    assign w_fe      = r_clk_prev & ~w_clk_s;
    // Timeout window: from clock release until the device has let both lines go idle.
    assign w_timed   = (r_state == S_SEND) || (r_state == S_STOP) ||
                       (r_state == S_ACK)  || (r_state == S_WAIT_IDLE);
    assign w_tmo_hit = w_timed && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= S_IDLE;
            r_clk_sync       <= '1;
            r_data_sync      <= '1;
            r_clk_prev       <= 1'b1;
            r_inh_cnt        <= '0;
            r_tmo_cnt        <= '0;
            r_shift          <= '0;
            r_bit_cnt        <= '0;
            o_ps2_clk_oe     <= 1'b0;
            o_ps2_data_oe    <= 1'b0;
            tx_if.tx_ready   <= 1'b1;
            tx_if.tx_done    <= 1'b0;
            tx_if.tx_err     <= 1'b0;
            tx_if.rx_inhibit <= 1'b0;
        end else begin
            r_clk_sync  <= (r_clk_sync << 1) | SYNC_STAGES'(i_ps2_clk);
            r_data_sync <= (r_data_sync << 1) | SYNC_STAGES'(i_ps2_data);
            r_clk_prev  <= w_clk_s;

            if (w_timed) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end

            if (w_tmo_hit) begin
                r_state       <= S_ERR;
                o_ps2_clk_oe  <= 1'b0;
                o_ps2_data_oe <= 1'b0;
                tx_if.tx_err  <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (tx_if.tx_valid) begin
                            r_shift          <= {~^tx_if.tx_data, tx_if.tx_data};
                            r_inh_cnt        <= '0;
                            o_ps2_clk_oe     <= 1'b1;
                            tx_if.tx_ready   <= 1'b0;
                            tx_if.rx_inhibit <= 1'b1;
                            r_state          <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        r_inh_cnt <= r_inh_cnt + INH_W'(1);
                        if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                            o_ps2_data_oe <= 1'b1;
                            r_state       <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        o_ps2_clk_oe <= 1'b0;
                        r_tmo_cnt    <= '0;
                        r_bit_cnt    <= '0;
                        r_state      <= S_SEND;
                    end
                    S_SEND: begin
                        if (w_fe) begin
                            o_ps2_data_oe <= ~r_shift[0];
                            r_shift       <= {1'b0, r_shift[8:1]};
                            r_bit_cnt     <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd8) begin
                                r_state <= S_STOP;
                            end
                        end
                    end
                    S_STOP: begin
                        if (w_fe) begin
                            o_ps2_data_oe <= 1'b0;
                            r_state       <= S_ACK;
                        end
                    end
                    S_ACK: begin
                        if (w_fe) begin
                            if (!w_data_s) begin
                                r_state <= S_WAIT_IDLE;
                            end else begin
                                tx_if.tx_err <= 1'b1;
                                r_state      <= S_ERR;
                            end
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (w_clk_s && w_data_s) begin
                            tx_if.tx_done <= 1'b1;
                            r_state       <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        tx_if.tx_done    <= 1'b0;
                        tx_if.tx_ready   <= 1'b1;
                        tx_if.rx_inhibit <= 1'b0;
                        r_state          <= S_IDLE;
                    end
                    S_ERR: begin
                        o_ps2_clk_oe     <= 1'b0;
                        o_ps2_data_oe    <= 1'b0;
                        tx_if.tx_err     <= 1'b0;
                        tx_if.tx_ready   <= 1'b1;
                        tx_if.rx_inhibit <= 1'b0;
                        r_state          <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 keyboard model clocks the frame out of the host, captures the bits
// and ACKs, NACKs, stalls or is interrupted by reset; results are checked against a byte-level model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int unsigned INH  = 20;
    localparam int unsigned TMO  = 5000;
    localparam int unsigned HALF = 20;
    localparam int M_ACK   = 0;
    localparam int M_NACK  = 1;
    localparam int M_STALL = 2;
    localparam int M_ABORT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic w_ps2_clk, w_ps2_data, w_clk_oe, w_data_oe;

    int n_vec  = 0;
    int n_fail = 0;

    int         dev_falls;
    bit         abort_req;
    logic [9:0] cap;
    int   rel_cyc, done_cyc, err_cyc, n_done, n_err, n_inh_only, n_inh_low;
    logic ready_after, oe_at_err, inj_ready;
    logic pre_data_oe, ab_clk_oe, ab_data_oe, ab_ready, ab_inh;

    always #5 clk = ~clk;

    assign w_ps2_clk  = ~(w_clk_oe | dev_clk_low);
    assign w_ps2_data = ~(w_data_oe | dev_data_low);

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .SYNC_STAGES   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_if        (bus.slave),
        .i_ps2_clk    (w_ps2_clk),
        .i_ps2_data   (w_ps2_data),
        .o_ps2_clk_oe (w_clk_oe),
        .o_ps2_data_oe(w_data_oe)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame as seen on the wire: data LSB first, odd parity, released stop bit.
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
    endfunction

    // Keyboard model: generates 11 clock pulses, samples the line before each rise.
    task automatic dev_run(input int mode);
        int w = 0;
        cap       = '0;
        dev_falls = 0;
        while (!(w_ps2_clk && !w_ps2_data) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200 || mode == M_STALL) return;
        repeat (HALF) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            if (abort_req) break;
            if (k == 11 && mode != M_NACK) dev_data_low = 1'b1;
            repeat (HALF / 2) @(negedge clk);
            dev_clk_low = 1'b1;
            dev_falls   = k;
            for (int j = 0; j < int'(HALF); j++) begin
                @(negedge clk);
                if (abort_req) break;
            end
            if (k <= 10) cap[k-1] = w_ps2_data;
            dev_clk_low = 1'b0;
            repeat (HALF / 2) @(negedge clk);
        end
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
    endtask

    // Requester side: issues the byte and watches the DUT outputs every cycle.
    task automatic host_run(input logic [7:0] d, input int mode, input bit inject);
        int  cyc     = 1;
        int  tail    = -1;
        int  f4_cyc  = -1;
        int  ab_cyc  = -1;
        bit  prev_oe = 1'b0;
        rel_cyc = -1; done_cyc = -1; err_cyc = -1;
        n_done = 0; n_err = 0; n_inh_only = 0; n_inh_low = 0;
        ready_after = 1'bx; oe_at_err = 1'bx; inj_ready = 1'bx;
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
        while (cyc < int'(TMO) + 400) begin
            if (w_clk_oe && !w_data_oe) n_inh_only++;
            if (!w_clk_oe && prev_oe && rel_cyc < 0) rel_cyc = cyc;
            prev_oe = w_clk_oe;
            if (tail < 0 && ab_cyc < 0 && !bus.rx_inhibit) n_inh_low++;
            if (bus.tx_done) begin n_done++; done_cyc = cyc; end
            if (bus.tx_err) begin n_err++; err_cyc = cyc; oe_at_err = w_clk_oe | w_data_oe; end
            if (tail < 0 && (bus.tx_done || bus.tx_err)) tail = cyc;
            if (tail >= 0 && cyc == tail + 1) ready_after = bus.tx_ready;
            if (tail >= 0 && cyc == tail + 40) break;
            if (inject && cyc == int'(INH) + 102) begin
                inj_ready    = bus.tx_ready;
                bus.tx_data  = 8'h55;
                bus.tx_valid = 1'b1;
            end
            if (inject && cyc == int'(INH) + 103) bus.tx_valid = 1'b0;
            if (mode == M_ABORT) begin
                if (f4_cyc < 0 && dev_falls >= 4) f4_cyc = cyc;
                if (f4_cyc >= 0 && ab_cyc < 0 && cyc == f4_cyc + 6) begin
                    pre_data_oe = w_data_oe;
                    #2 rst = 1'b0;
                    #1;
                    ab_clk_oe  = w_clk_oe;
                    ab_data_oe = w_data_oe;
                    ab_ready   = bus.tx_ready;
                    ab_inh     = bus.rx_inhibit;
                    abort_req  = 1'b1;
                    ab_cyc     = cyc;
                end
                if (ab_cyc >= 0 && cyc == ab_cyc + 40) break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input int mode, input bit inject);
        abort_req = 1'b0;
        fork
            dev_run(mode);
            host_run(d, mode, inject);
        join
    endtask

    task automatic check_ack(input string tag, input logic [7:0] d);
        chk({tag, "_wire"},     32'(cap), 32'(model_frame(d)));
        chk({tag, "_done"},     32'(n_done), 32'd1);
        chk({tag, "_err"},      32'(n_err), 32'd0);
        chk({tag, "_inh_len"},  32'(n_inh_only), 32'(INH));
        chk({tag, "_release"},  32'(rel_cyc), 32'(INH + 2));
        chk({tag, "_inh_gap"},  32'(n_inh_low), 32'd0);
        chk({tag, "_ready_nx"}, 32'(ready_after), 32'd1);
        chk({tag, "_inh_idle"}, 32'(bus.rx_inhibit), 32'd0);
    endtask

    initial begin
        logic [7:0] rb;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready",   32'(bus.tx_ready), 32'd1);
        chk("rst_inhibit", 32'(bus.rx_inhibit), 32'd0);
        chk("rst_clk_oe",  32'(w_clk_oe), 32'd0);
        chk("rst_data_oe", 32'(w_data_oe), 32'd0);
        chk("rst_done",    32'(bus.tx_done), 32'd0);
        chk("rst_err",     32'(bus.tx_err), 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        run_frame(8'hED, M_ACK, 1'b0);
        chk("ed_bits", 32'(cap), 32'h3ED);
        check_ack("ed", 8'hED);

        run_frame(8'h00, M_ACK, 1'b0);
        check_ack("x00", 8'h00);
        run_frame(8'hFF, M_ACK, 1'b0);
        check_ack("xff", 8'hFF);
        run_frame(8'h01, M_ACK, 1'b0);
        check_ack("x01", 8'h01);

        run_frame(8'hED, M_ACK, 1'b1);
        chk("inj_ready", 32'(inj_ready), 32'd0);
        check_ack("inj", 8'hED);

        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            run_frame(rb, M_ACK, 1'b0);
            check_ack("rnd", rb);
        end

        rb = 8'($urandom);
        run_frame(rb, M_NACK, 1'b0);
        chk("nack_err",   32'(n_err), 32'd1);
        chk("nack_done",  32'(n_done), 32'd0);
        chk("nack_ready", 32'(ready_after), 32'd1);
        chk("nack_oe",    32'(oe_at_err), 32'd0);
        chk("nack_wire",  32'(cap), 32'(model_frame(rb)));

        run_frame(8'hED, M_STALL, 1'b0);
        chk("tmo_err",   32'(n_err), 32'd1);
        chk("tmo_done",  32'(n_done), 32'd0);
        chk("tmo_delay", 32'(err_cyc - rel_cyc), 32'(TMO));
        chk("tmo_oe",    32'(oe_at_err), 32'd0);
        chk("tmo_ready", 32'(ready_after), 32'd1);

        run_frame(8'hA5, M_ABORT, 1'b0);
        chk("abort_pre_data", 32'(pre_data_oe), 32'd1);
        chk("abort_clk_oe",   32'(ab_clk_oe), 32'd0);
        chk("abort_data_oe",  32'(ab_data_oe), 32'd0);
        chk("abort_ready",    32'(ab_ready), 32'd1);
        chk("abort_inhibit",  32'(ab_inh), 32'd0);
        chk("abort_pulses",   32'(n_done + n_err), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        run_frame(8'hF4, M_ACK, 1'b0);
        check_ack("f4", 8'hF4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
